mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, consecutive fetch denials before forced fetch grant (range 1..15).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port if_req  input  1  fetch request, level, held until if_ack.
REQ-007 SHALL have port if_addr  input  AW  fetch address (PC).
REQ-008 SHALL have port if_ack  output  1  one-cycle fetch completion pulse.
REQ-009 SHALL have port if_rdata  output  DW  fetched instruction, valid with if_ack.
REQ-010 SHALL have port dm_req  input  1  data request, level, held until dm_ack.
REQ-011 SHALL have port dm_we  input  1  1 = store, 0 = load.
REQ-012 SHALL have port dm_addr  input  AW  data address.
REQ-013 SHALL have port dm_wdata  input  DW  store data.
REQ-014 SHALL have port dm_ack  output  1  one-cycle data completion pulse.
REQ-015 SHALL have port dm_rdata  output  DW  load data, valid with dm_ack.
REQ-016 SHALL have ports mem_req/mem_we (output 1), mem_addr (output AW), mem_wdata (output DW): single-port memory command.
REQ-017 SHALL have ports mem_ready (input 1), mem_rdata (input DW): memory completion and read data.
REQ-018 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, GNT_IF, GNT_DM, RESP.
REQ-020 IDLE: requests sampled only here; none -> stay IDLE; grant chosen per REQ-021/REQ-034; command latched into mem_addr/mem_we/mem_wdata at transition edge.
REQ-021 Base priority: dm_req wins over if_req when both high (data belongs to older instruction).
REQ-022 GNT_IF/GNT_DM: mem_req high, command registers stable; stay while mem_ready low; on mem_req&&mem_ready capture mem_rdata and go to RESP.
REQ-023 Fetch command SHALL drive mem_we=0 and mem_wdata=0.
REQ-024 RESP: exactly one of if_ack/dm_ack high for one cycle; mem_req low; next state IDLE unconditionally.
REQ-025 if_rdata updates only on fetch completion; dm_rdata updates only on load completion; both hold value otherwise (stores leave dm_rdata unchanged).
REQ-026 Latency: request seen in IDLE at edge N -> mem_req high cycle N+1 -> ack cycle N+2 minimum (mem_ready high first cycle); each extra mem_ready-low cycle adds one.
REQ-027 Throughput: at most one transaction per 3 cycles; requester drops or updates its req at the edge ending its ack cycle; a req still high in IDLE is a new request.
REQ-028 Requests deasserted while in GNT_* SHALL NOT abort the memory command.
REQ-029 mem_ready outside GNT_* SHALL be ignored.
REQ-030 Address/data are passed through unmodified; no alignment checks.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ack=0, dm_ack=0, if_rdata=0, dm_rdata=0, busy=0, starvation counter=0.
REQ-032 Reset mid-transaction SHALL drop the transaction without ack; requesters reissue after release.
REQ-033 First arbitration SHALL occur at the first rising clk edge with rst_n high.

Configuration
REQ-034 With ARB_STARVE_GUARD_EN defined: 4-bit counter increments on each DM grant while if_req high, clears on IF grant; when counter == STARVE_MAX, next arbitration grants IF even if dm_req high.
REQ-035 Without ARB_STARVE_GUARD_EN: no counter; strict data priority per REQ-021.

Verification
REQ-036 Reset: rst_n low 3 cycles with if_req=1 -> mem_req=0, acks=0, busy=0; after release if_addr=0x00000000 issued next cycle.
REQ-037 Fetch: if_req=1, if_addr=0x00000004, mem_ready=1, mem_rdata=0x8C010000 -> mem_req high one cycle, if_ack pulse with if_rdata=0x8C010000 two cycles after sampling.
REQ-038 Contention: if_req=1, dm_req=1 dm_we=1 dm_addr=0x10 dm_wdata=0xDEADBEEF -> store issued first (mem_we=1), then fetch; dm_rdata unchanged.
REQ-039 Wait states: load dm_addr=0x20, mem_ready low 3 cycles then high with 0x0000002A -> mem_req held 4 cycles, dm_ack with dm_rdata=0x0000002A.
REQ-040 Starvation (macro defined, STARVE_MAX=4): if_req and dm_req held high -> 4 DM grants then IF grant; macro undefined -> no IF grant while dm_req high.
REQ-041 Reset mid-operation: rst_n low while in GNT_DM with mem_ready low -> mem_req drops same cycle, no dm_ack afterwards.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, data port and the single-port
// memory command/response. The arbiter connects through the slave modport;
// requesters and the memory model sit on the master side.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Instruction fetch port
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  // Data port
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;
  // Memory command and completion
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ready, mem_rdata,
    output if_ack, if_rdata, dm_ack, dm_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ready, mem_rdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between an instruction fetch
// port and a data port. One transaction at a time: IDLE -> GNT_* -> RESP.
// Data requests win over fetches. Optional macro ARB_STARVE_GUARD_EN adds a
// 4-bit denial counter that forces a fetch grant after STARVE_MAX data grants
// taken while a fetch was waiting.
module mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_arbiter_if.slave   bus,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_DM, RESP} state_t;

  state_t        state, state_next;
  logic          sel_dm;        // owner of the in-flight / responding transaction
  logic [AW-1:0] cmd_addr;
  logic          cmd_we;
  logic [DW-1:0] cmd_wdata;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] dm_rdata_q;
  logic          grant_if, grant_dm;
  logic          mem_req_c, if_ack_c, dm_ack_c;

  // Reject starvation limits the 4-bit counter cannot represent.
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("mem_arbiter: STARVE_MAX must be in 1..15");
  end

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt;
  logic       starve_hit;
  assign starve_hit = (starve_cnt == 4'(STARVE_MAX));

  // Grant choice: data first, unless the fetch side has been denied too often.
  always_comb begin
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (bus.dm_req && !(bus.if_req && starve_hit)) grant_dm = 1'b1;
    else if (bus.if_req)                           grant_if = 1'b1;
  end

  // Count data grants taken over a pending fetch; an IF grant clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_if)                    starve_cnt <= '0;
      else if (grant_dm && bus.if_req) starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  // Grant choice: strict data priority.
  always_comb begin
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (bus.dm_req)      grant_dm = 1'b1;
    else if (bus.if_req) grant_if = 1'b1;
  end
`endif

  // Next-state and handshake outputs; requests are only looked at in IDLE.
  always_comb begin
    state_next = state;
    mem_req_c  = 1'b0;
    if_ack_c   = 1'b0;
    dm_ack_c   = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (grant_dm)      state_next = GNT_DM;
        else if (grant_if) state_next = GNT_IF;
      end
      GNT_IF, GNT_DM: begin
        mem_req_c = 1'b1;
        if (bus.mem_ready) state_next = RESP;
      end
      RESP: begin
        if_ack_c   = !sel_dm;
        dm_ack_c   = sel_dm;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, command latch at grant, read-data capture at completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel_dm     <= 1'b0;
      cmd_addr   <= '0;
      cmd_we     <= 1'b0;
      cmd_wdata  <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        if (grant_dm) begin
          sel_dm    <= 1'b1;
          cmd_addr  <= bus.dm_addr;
          cmd_we    <= bus.dm_we;
          cmd_wdata <= bus.dm_wdata;
        end else if (grant_if) begin
          // A fetch is always a read with a zeroed write bus.
          sel_dm    <= 1'b0;
          cmd_addr  <= bus.if_addr;
          cmd_we    <= 1'b0;
          cmd_wdata <= '0;
        end
      end
      if (state == GNT_IF && bus.mem_ready)            if_rdata_q <= bus.mem_rdata;
      if (state == GNT_DM && bus.mem_ready && !cmd_we) dm_rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.mem_req   = mem_req_c;
  assign bus.mem_we    = cmd_we;
  assign bus.mem_addr  = cmd_addr;
  assign bus.mem_wdata = cmd_wdata;
  assign bus.if_ack    = if_ack_c;
  assign bus.dm_ack    = dm_ack_c;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;

endmodule
